linear_cordic_rotation_mode: RTL and testbench

- 16-stage pipelined linear CORDIC in rotation mode; computes the multiply-accumulate Y_O = Y_i + X_i*Z_i and drives Z toward zero.
- Forward counterpart of the linear vectoring-mode divider (Z += Y/X).
- Shares that block's Q2.14 signed format (16384 = 1.0).
- Feeds downstream scaling/MAC paths.
- Accepts one sample per cycle; a valid bit travels alongside the data.

---
 rtl/linear_cordic_pkg.sv | 27 ++
 rtl/linear_cordic_rotation_stage.sv | 82 ++++++++
 rtl/linear_cordic_rotation_mode.sv | 95 +++++++++
 tb/tb_linear_cordic_rotation_mode.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/linear_cordic_pkg.sv
// -----------------------------------------------------------------------------
// linear_cordic_pkg
// Shared configuration for the linear rotation-mode CORDIC (Q2.14 signed,
// 16384 = 1.0) and the per-stage rotation constant.
//   WIDTH  : signed I/O word width
//   FRAC   : fractional bits
//   STAGES : iteration / pipeline depth
//   GUARD  : extra integer bits on the internal Y datapath
//   YW     : internal Y width (WIDTH + GUARD)
// -----------------------------------------------------------------------------
package linear_cordic_pkg;

  localparam int WIDTH  = 16;
  localparam int FRAC   = 14;
  localparam int STAGES = 16;
  localparam int GUARD  = 2;
  localparam int YW     = WIDTH + GUARD;

  // C_i = 2^(FRAC-i) while the step is still representable, 0 beyond FRAC.
  function automatic logic signed [WIDTH-1:0] stage_const(input int i);
    if (i <= FRAC) begin
      return WIDTH'(1 << (FRAC - i));
    end
    return '0;
  endfunction

endpackage : linear_cordic_pkg

// File: rtl/linear_cordic_rotation_stage.sv
// -----------------------------------------------------------------------------
// linear_cordic_rotation_stage
// One registered linear-CORDIC rotation iteration:
//   d      = +1 if z >= 0 else -1
//   y_next = y + d * (x >>> SHIFT)      (arithmetic shift, truncating)
//   z_next = z - d * C_SHIFT
//   x, valid pass through unchanged.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   valid_i/x_i/y_i/z_i : stage inputs (y is YW bits, x and z WIDTH bits)
//   valid_o/x_o/y_o/z_o : registered stage outputs
// -----------------------------------------------------------------------------
module linear_cordic_rotation_stage
  import linear_cordic_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [YW-1:0]    y_i,
  input  logic signed [WIDTH-1:0] z_i,
  output logic                    valid_o,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [YW-1:0]    y_o,
  output logic signed [WIDTH-1:0] z_o
);

  localparam logic signed [WIDTH-1:0] C_STEP = stage_const(SHIFT);

  logic signed [YW-1:0]    x_ext;
  logic signed [YW-1:0]    x_shift;
  logic                    d_pos;

  logic                    valid_d, valid_q;
  logic signed [WIDTH-1:0] x_d, x_q;
  logic signed [YW-1:0]    y_d, y_q;
  logic signed [WIDTH-1:0] z_d, z_q;

  // x is widened before shifting so the guard bits of y see a correct sign.
  assign x_ext   = {{GUARD{x_i[WIDTH-1]}}, x_i};
  assign x_shift = x_ext >>> SHIFT;
  assign d_pos   = ~z_i[WIDTH-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    valid_d = valid_i;
    x_d     = x_i;
    y_d     = y_i - x_shift;
    z_d     = z_i + C_STEP;
    if (d_pos) begin
      y_d = y_i + x_shift;
      z_d = z_i - C_STEP;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are cleared too (not just valid), so the
    // outputs read 0 immediately after a reset edge.
    if (reset) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every stage samples
      // the previous stage's value from before this edge.
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign z_o     = z_q;

endmodule : linear_cordic_rotation_stage

// File: rtl/linear_cordic_rotation_mode.sv
// -----------------------------------------------------------------------------
// linear_cordic_rotation_mode
// 16-stage pipelined linear CORDIC in rotation mode. Computes the Q2.14
// multiply-accumulate Y_O = Y_i + X_i*Z_i while driving Z toward zero.
// One sample per cycle, fixed latency STAGES, no backpressure.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   valid_i         : input sample valid
//   X_i, Y_i, Z_i   : multiplicand, accumulator seed, multiplier (|Z_i| < 2.0)
//   valid_O         : output sample valid
//   X_O             : X_i delayed STAGES cycles
//   Y_O             : Y_i + X_i*Z_i
//   Z_O             : residual multiplier (ideally ~0)
//   sat_O           : Y_O was clamped (only with LINEAR_CORDIC_SATURATE_EN)
// Build option: define LINEAR_CORDIC_SATURATE_EN to clamp Y_O to the WIDTH-bit
// range and add sat_O; otherwise Y_O wraps (low WIDTH bits of internal y).
// -----------------------------------------------------------------------------
module linear_cordic_rotation_mode
  import linear_cordic_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic signed [WIDTH-1:0] X_i,
  input  logic signed [WIDTH-1:0] Y_i,
  input  logic signed [WIDTH-1:0] Z_i,
  output logic                    valid_O,
  output logic signed [WIDTH-1:0] X_O,
  output logic signed [WIDTH-1:0] Y_O,
`ifdef LINEAR_CORDIC_SATURATE_EN
  output logic                    sat_O,
`endif
  output logic signed [WIDTH-1:0] Z_O
);

  // Index 0 is the port side; index i+1 is the register output of stage i.
  logic                    valid_s [STAGES+1];
  logic signed [WIDTH-1:0] x_s     [STAGES+1];
  logic signed [YW-1:0]    y_s     [STAGES+1];
  logic signed [WIDTH-1:0] z_s     [STAGES+1];

  assign valid_s[0] = valid_i;
  assign x_s[0]     = X_i;
  assign y_s[0]     = {{GUARD{Y_i[WIDTH-1]}}, Y_i};
  assign z_s[0]     = Z_i;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    linear_cordic_rotation_stage #(
      .SHIFT (i)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .valid_i (valid_s[i]),
      .x_i     (x_s[i]),
      .y_i     (y_s[i]),
      .z_i     (z_s[i]),
      .valid_o (valid_s[i+1]),
      .x_o     (x_s[i+1]),
      .y_o     (y_s[i+1]),
      .z_o     (z_s[i+1])
    );
  end

  logic signed [YW-1:0] y_fin;
  assign y_fin = y_s[STAGES];

  assign valid_O = valid_s[STAGES];
  assign X_O     = x_s[STAGES];
  assign Z_O     = z_s[STAGES];

`ifdef LINEAR_CORDIC_SATURATE_EN
  localparam logic signed [WIDTH-1:0] Y_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] Y_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // y fits in WIDTH bits only when the guard bits and the WIDTH-bit sign bit
  // all agree.
  logic y_ovf;
  assign y_ovf = ~((&y_fin[YW-1:WIDTH-1]) | ~(|y_fin[YW-1:WIDTH-1]));

  always_comb begin
    Y_O = y_fin[WIDTH-1:0];
    if (y_ovf) begin
      Y_O = y_fin[YW-1] ? Y_MIN : Y_MAX;
    end
  end

  assign sat_O = y_ovf & valid_O;
`else
  // Guard bits are intentionally dropped in wrap mode.
  logic [GUARD-1:0] y_hi_unused;
  assign y_hi_unused = y_fin[YW-1:WIDTH];
  assign Y_O         = y_fin[WIDTH-1:0];
`endif

endmodule : linear_cordic_rotation_mode

// File: tb/tb_linear_cordic_rotation_mode.sv
// -----------------------------------------------------------------------------
// tb_linear_cordic_rotation_mode
// Scoreboard bench: the driver pushes the expected response for every valid
// sample; a negedge monitor pops and compares whenever valid_O is high.
// -----------------------------------------------------------------------------
module tb_linear_cordic_rotation_mode;
  import linear_cordic_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    valid_i;
  logic signed [WIDTH-1:0] X_i, Y_i, Z_i;
  logic                    valid_O;
  logic signed [WIDTH-1:0] X_O, Y_O, Z_O;
`ifdef LINEAR_CORDIC_SATURATE_EN
  logic                    sat_O;
`endif

  linear_cordic_rotation_mode dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .X_i     (X_i),
    .Y_i     (Y_i),
    .Z_i     (Z_i),
    .valid_O (valid_O),
    .X_O     (X_O),
    .Y_O     (Y_O),
`ifdef LINEAR_CORDIC_SATURATE_EN
    .sat_O   (sat_O),
`endif
    .Z_O     (Z_O)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // z_mode 0: |Z_O| <= 2; z_mode 1: Z_O must be nonzero. y_tol < 0: skip Y.
  typedef struct {
    int x;
    int y_exp;
    int y_tol;
    int z_mode;
    int sat;
    int issue;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one sample for one cycle; optionally register its expectation.
  task automatic send(input int x, input int y, input int z, input int y_exp,
                      input int y_tol, input int z_mode, input int sat, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    X_i     = 16'(x);
    Y_i     = 16'(y);
    Z_i     = 16'(z);
    if (push) begin
      e.x = x; e.y_exp = y_exp; e.y_tol = y_tol; e.z_mode = z_mode;
      e.sat = sat; e.issue = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      X_i = '0; Y_i = '0; Z_i = '0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 64 && sb.size() != 0; i++) @(posedge clk);
    check("drain_timeout", sb.size() == 0, sb.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid_O"}, valid_O == 1'b0, int'(valid_O), 0);
    check({tag, "_X_O"}, X_O == '0, int'(X_O), 0);
    check({tag, "_Y_O"}, Y_O == '0, int'(Y_O), 0);
    check({tag, "_Z_O"}, Z_O == '0, int'(Z_O), 0);
  endtask

  // Monitor: any valid_O with an empty scoreboard is an unexpected sample.
  always @(negedge clk) begin
    if (valid_O) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_O", 1'b0, int'(Y_O), 0);
      end else begin
        mon_e = sb.pop_front();
        check("latency", (cyc - mon_e.issue) == STAGES, cyc - mon_e.issue, STAGES);
        check("X_O", int'(X_O) == mon_e.x, int'(X_O), mon_e.x);
        if (mon_e.y_tol >= 0)
          check("Y_O", iabs(int'(Y_O) - mon_e.y_exp) <= mon_e.y_tol, int'(Y_O), mon_e.y_exp);
        if (mon_e.z_mode == 0)
          check("Z_O_residual", iabs(int'(Z_O)) <= 2, int'(Z_O), 0);
        else
          check("Z_O_nonzero", Z_O != '0, int'(Z_O), 1);
`ifdef LINEAR_CORDIC_SATURATE_EN
        check("sat_O", int'(sat_O) == mon_e.sat, int'(sat_O), mon_e.sat);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x, y, z, p, lo, hi;

    reset = 1'b1; valid_i = 1'b0; X_i = '0; Y_i = '0; Z_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;

    // Single sample: 1.0 * 0.5; exactly one valid_O pulse expected.
    send(16384, 0, 8192, 8192, 16, 0, 0, 1'b1);
    idle(1);
    wait_drain();
    idle(4);

    // Isolated directed vectors.
    send(8192, 0, -8192, -4096, 16, 0, 0, 1'b1);   idle(1);
    send(16384, 0, 12288, 12288, 16, 0, 0, 1'b1);  idle(1);
    send(8192, 0, 16384, 8192, 16, 0, 0, 1'b1);    idle(1);
    // Z = 0 leaves Y unchanged.
    send(12345, 1000, 0, 1000, 16, 0, 0, 1'b1);    idle(1);
    // X = -2.0 is legal.
    send(-32768, 0, 8192, -16384, 16, 0, 0, 1'b1); idle(1);
    send(-32768, 0, -8192, 16384, 16, 0, 0, 1'b1); idle(1);
    // Largest convergent |Z|: 8192*32767/16384 = 16383.5.
    send(8192, 0, 32767, 16384, 16, 0, 0, 1'b1);   idle(1);
    // Z = -2.0 is outside the convergence range: residual must be nonzero.
    send(4096, 0, -32768, 0, -1, 1, 0, 1'b1);      idle(1);
    wait_drain();

    // Back-to-back burst of 6.
    send(16384, 0, 8192, 8192, 16, 0, 0, 1'b1);
    send(13107, 1638, 8192, 8192, 16, 0, 0, 1'b1);
    send(8192, 0, -8192, -4096, 16, 0, 0, 1'b1);
    send(-16384, 4000, 4096, -96, 16, 0, 0, 1'b1);
    send(10000, -5000, -16384, -15000, 16, 0, 0, 1'b1);
    send(20000, 100, 20000, 24514, 16, 0, 0, 1'b1);
    idle(1);
    wait_drain();

    // Overflow: 16384 + 32767*1.5 = 65534.5.
`ifdef LINEAR_CORDIC_SATURATE_EN
    send(32767, 16384, 24576, 32767, 0, 0, 1, 1'b1);
`else
    send(32767, 16384, 24576, -2, 16, 0, 0, 1'b1);
`endif
    idle(1);
    wait_drain();

    // Mid-burst reset: none of these samples may ever reach valid_O.
    for (int i = 0; i < 5; i++) send(16384, 0, 8192, 0, 0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_zero_outputs("flush");
    idle(24);

    // Random samples against the ideal rounded product, kept in range.
    for (int n = 0; n < 1000; n++) begin
      x  = int'($urandom_range(0, 32766)) - 16383;
      z  = int'($urandom_range(0, 65532)) - 32766;
      p  = (x * z + 8192) >>> 14;
      lo = (-32700 - p < -32768) ? -32768 : -32700 - p;
      hi = (32700 - p > 32767) ? 32767 : 32700 - p;
      y  = lo + int'($urandom_range(0, hi - lo));
      send(x, y, z, y + p, 16, 0, 0, 1'b1);
    end
    idle(1);
    wait_drain();
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_linear_cordic_rotation_mode
